// File: rtl/trigger_qualifier.sv
// rtl/trigger_qualifier.sv - trigger pin synchroniser, glitch filter, edge selector and edge counter
//
// Conditions the raw external trigger pin before it feeds the glitch generator.
// Optional feature macro: TRIG_QUAL_TIMEOUT_EN (armed timeout; when undefined,
// ARMED persists indefinitely and timeout is tied 0).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   trig_raw   in   raw trigger pin, asynchronous to clk
//   arm        in   single-cycle arm / re-arm request
//   edge_sel   in   1 = rising, 0 = falling; latched on arm
//   edge_count in   qualified edges required before firing; latched on arm, 0 treated as 1
//   trig_out   out  single-cycle pulse to the glitch generator
//   armed      out  high while ARMED
//   fired      out  high while FIRED
//   level      out  filtered trigger level
//   timeout    out  single-cycle pulse on armed timeout

module trigger_qualifier #(
    parameter int                  SYNC_STAGES    = 2,
    parameter int                  FILTER_W       = 16,
    parameter logic [FILTER_W-1:0] FILTER_CYCLES  = 16'd12,
    parameter int                  COUNT_W        = 8,
    parameter logic [31:0]         TIMEOUT_CYCLES = 32'd12_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig_raw,
    input  logic               arm,
    input  logic               edge_sel,
    input  logic [COUNT_W-1:0] edge_count,
    output logic               trig_out,
    output logic               armed,
    output logic               fired,
    output logic               level,
    output logic               timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ARMED = 3'b010,
        FIRED = 3'b100
    } state_t;

    localparam logic [FILTER_W-1:0] FILT_LAST = FILTER_CYCLES - 1'b1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_W-1:0]    filt_cnt_q, filt_cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q, level_dly_d;
    state_t                 state_q, state_d;
    logic [COUNT_W-1:0]     rem_q, rem_d;
    logic                   sel_q, sel_d;
    logic                   trig_out_q, trig_out_d;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   sel_edge;
    logic [COUNT_W-1:0]     load_count;

`ifdef TRIG_QUAL_TIMEOUT_EN
    logic [31:0]            tmr_q, tmr_d;
    logic                   timeout_q, timeout_d;
`endif

    // Synchroniser chain; s is the last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trig_raw};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Glitch filter: s must differ from level for FILTER_CYCLES consecutive
    // samples before level follows it. The counter holds (samples seen - 1),
    // so the accepting sample is the one that finds it at FILT_LAST.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        level_d    = level_q;
        if (FILTER_CYCLES == '0) begin
            level_d    = s;
            filt_cnt_d = '0;
        end else if (s == level_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q >= FILT_LAST) begin
            level_d    = s;
            filt_cnt_d = '0;
        end else if (filt_cnt_q != '1) begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        level_dly_d = level_q;
    end

    assign rise       = level_q & ~level_dly_q;
    assign fall       = ~level_q & level_dly_q;
    assign sel_edge   = sel_q ? rise : fall;
    assign load_count = (edge_count == '0) ? COUNT_W'(1) : edge_count;

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            filt_cnt_q  <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rem_q       <= '0;
            sel_q       <= 1'b0;
            trig_out_q  <= 1'b0;
`ifdef TRIG_QUAL_TIMEOUT_EN
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            filt_cnt_q  <= filt_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            trig_out_q  <= trig_out_d;
`ifdef TRIG_QUAL_TIMEOUT_EN
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. arm wins over everything in every state: it reloads the
    // latches and swallows any edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sel_d      = sel_q;
        trig_out_d = 1'b0;
`ifdef TRIG_QUAL_TIMEOUT_EN
        tmr_d      = tmr_q;
        timeout_d  = 1'b0;
`endif
        if (arm) begin
            state_d = ARMED;
            rem_d   = load_count;
            sel_d   = edge_sel;
`ifdef TRIG_QUAL_TIMEOUT_EN
            tmr_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ARMED: begin
`ifdef TRIG_QUAL_TIMEOUT_EN
                    tmr_d = tmr_q + 32'd1;
`endif
                    if (sel_edge && (rem_q <= COUNT_W'(1))) begin
                        // Firing edge takes priority over a coincident timeout.
                        state_d    = FIRED;
                        trig_out_d = 1'b1;
                    end else begin
                        if (sel_edge) begin
                            rem_d = rem_q - 1'b1;
                        end
`ifdef TRIG_QUAL_TIMEOUT_EN
                        if (tmr_q == TIMEOUT_CYCLES - 32'd1) begin
                            state_d   = IDLE;
                            timeout_d = 1'b1;
                        end
`endif
                    end
                end
                FIRED: begin
                    state_d = FIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM outputs, decoded from the one-hot registered state.
    always_comb begin
        armed    = (state_q == ARMED);
        fired    = (state_q == FIRED);
        trig_out = trig_out_q;
        level    = level_q;
    end

`ifdef TRIG_QUAL_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_qualifier.sv
// tb/tb_trigger_qualifier.sv - directed self-checking bench for trigger_qualifier

module tb_trigger_qualifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig_raw;
    logic       arm;
    logic       edge_sel;
    logic [7:0] edge_count;
    logic       trig_out;
    logic       armed;
    logic       fired;
    logic       level;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trigger_qualifier #(
        .SYNC_STAGES   (2),
        .FILTER_W      (16),
        .FILTER_CYCLES (16'd12),
        .COUNT_W       (8),
        .TIMEOUT_CYCLES(32'd12_000_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig_raw  (trig_raw),
        .arm       (arm),
        .edge_sel  (edge_sel),
        .edge_count(edge_count),
        .trig_out  (trig_out),
        .armed     (armed),
        .fired     (fired),
        .level     (level),
        .timeout   (timeout)
    );

`ifdef TRIG_QUAL_TIMEOUT_EN
    logic       to_raw = 1'b0;
    logic       to_arm = 1'b0;
    logic       to_sel = 1'b1;
    logic [7:0] to_cnt = 8'd1;
    logic       to_trig, to_armed, to_fired, to_level, to_timeout;

    trigger_qualifier #(
        .SYNC_STAGES   (2),
        .FILTER_W      (16),
        .FILTER_CYCLES (16'd12),
        .COUNT_W       (8),
        .TIMEOUT_CYCLES(32'd100)
    ) dut_to (
        .clk       (clk),
        .rst       (rst),
        .trig_raw  (to_raw),
        .arm       (to_arm),
        .edge_sel  (to_sel),
        .edge_count(to_cnt),
        .trig_out  (to_trig),
        .armed     (to_armed),
        .fired     (to_fired),
        .level     (to_level),
        .timeout   (to_timeout)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_with(input logic sel, input logic [7:0] cnt);
        edge_sel   = sel;
        edge_count = cnt;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic settle_low();
        trig_raw = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; trig_raw = 1'b0; arm = 1'b0; edge_sel = 1'b1; edge_count = 8'd1;
        repeat (3) tick();
        n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL reset_trig_out got %b want 0", trig_out); end
        n_checks++; if (armed !== 1'b0)    begin n_fail++; $display("FAIL reset_armed got %b want 0", armed); end
        n_checks++; if (fired !== 1'b0)    begin n_fail++; $display("FAIL reset_fired got %b want 0", fired); end
        n_checks++; if (level !== 1'b0)    begin n_fail++; $display("FAIL reset_level got %b want 0", level); end
        n_checks++; if (timeout !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst = 1'b0;
        tick();
        n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL post_reset_armed got %b want 0", armed); end
    endtask

    task automatic test_basic_fire();
        arm_with(1'b1, 8'd1);
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed got %b want 1", armed); end
        n_checks++; if (fired !== 1'b0) begin n_fail++; $display("FAIL basic_fired0 got %b want 0", fired); end
        trig_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++; if (trig_out !== (k == 14)) begin n_fail++; $display("FAIL basic_trig k=%0d got %b want %b", k, trig_out, (k == 14)); end
            n_checks++; if (level !== (k >= 13))    begin n_fail++; $display("FAIL basic_level k=%0d got %b want %b", k, level, (k >= 13)); end
            n_checks++; if (fired !== (k >= 14))    begin n_fail++; $display("FAIL basic_fired k=%0d got %b want %b", k, fired, (k >= 14)); end
            n_checks++; if (armed !== (k < 14))     begin n_fail++; $display("FAIL basic_armedk k=%0d got %b want %b", k, armed, (k < 14)); end
        end
        settle_low();
    endtask

    task automatic test_filter();
        int pulses;
        int first_at;
        int level_hi;
        // Re-arm out of FIRED.
        arm_with(1'b1, 8'd1);
        n_checks++; if (fired !== 1'b0) begin n_fail++; $display("FAIL rearm_fired got %b want 0", fired); end
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL rearm_armed got %b want 1", armed); end
        // 11-cycle pulse must be rejected.
        pulses = 0; level_hi = 0;
        for (int k = 0; k < 31; k++) begin
            trig_raw = (k < 11);
            tick();
            if (trig_out) pulses++;
            if (level) level_hi++;
        end
        n_checks++; if (level_hi != 0) begin n_fail++; $display("FAIL filter_short_level got %0d high cycles want 0", level_hi); end
        n_checks++; if (pulses != 0)   begin n_fail++; $display("FAIL filter_short_trig got %0d pulses want 0", pulses); end
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL filter_short_armed got %b want 1", armed); end
        // 12-cycle pulse must be accepted.
        pulses = 0; first_at = -1;
        for (int k = 0; k < 30; k++) begin
            trig_raw = (k < 12);
            tick();
            if (k == 13) begin
                n_checks++; if (level !== 1'b1) begin n_fail++; $display("FAIL filter_min_level got %b want 1", level); end
            end
            if (trig_out) begin pulses++; if (first_at < 0) first_at = k; end
        end
        n_checks++; if (pulses != 1)    begin n_fail++; $display("FAIL filter_min_pulses got %0d want 1", pulses); end
        n_checks++; if (first_at != 14) begin n_fail++; $display("FAIL filter_min_at got %0d want 14", first_at); end
        settle_low();
    endtask

    task automatic test_edge_count();
        int pulses;
        int first_at;
        arm_with(1'b0, 8'd3);
        pulses = 0; first_at = -1;
        for (int i = 0; i < 260; i++) begin
            trig_raw = (i < 240) && ((i % 60) < 30);
            tick();
            if (trig_out) begin pulses++; if (first_at < 0) first_at = i; end
        end
        n_checks++; if (pulses != 1)     begin n_fail++; $display("FAIL count3_pulses got %0d want 1", pulses); end
        n_checks++; if (first_at != 164) begin n_fail++; $display("FAIL count3_at got %0d want 164", first_at); end
        n_checks++; if (fired !== 1'b1)  begin n_fail++; $display("FAIL count3_fired got %b want 1", fired); end
        // edge_count of 0 behaves as 1.
        arm_with(1'b1, 8'd0);
        pulses = 0; first_at = -1;
        trig_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (trig_out) begin pulses++; if (first_at < 0) first_at = k; end
        end
        n_checks++; if (pulses != 1)    begin n_fail++; $display("FAIL count0_pulses got %0d want 1", pulses); end
        n_checks++; if (first_at != 14) begin n_fail++; $display("FAIL count0_at got %0d want 14", first_at); end
        settle_low();
    endtask

    task automatic test_restart();
        int pulses;
        int first_at;
        arm_with(1'b1, 8'd1);
        edge_count = 8'd2;
        pulses = 0; first_at = -1;
        for (int i = 0; i < 200; i++) begin
            trig_raw = (i < 180) && ((i % 60) < 30);
            arm      = (i == 14);
            tick();
            arm = 1'b0;
            if (i == 14) begin
                n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL restart_trig got %b want 0", trig_out); end
                n_checks++; if (armed !== 1'b1)    begin n_fail++; $display("FAIL restart_armed got %b want 1", armed); end
            end
            if (trig_out) begin pulses++; if (first_at < 0) first_at = i; end
        end
        n_checks++; if (pulses != 1)     begin n_fail++; $display("FAIL restart_pulses got %0d want 1", pulses); end
        n_checks++; if (first_at != 134) begin n_fail++; $display("FAIL restart_at got %0d want 134", first_at); end
        settle_low();
    endtask

    task automatic test_reset_mid();
        int pulses;
        int armed_hi;
        arm_with(1'b1, 8'd1);
        trig_raw = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (armed !== 1'b0)    begin n_fail++; $display("FAIL midfilt_armed got %b want 0", armed); end
        n_checks++; if (fired !== 1'b0)    begin n_fail++; $display("FAIL midfilt_fired got %b want 0", fired); end
        n_checks++; if (level !== 1'b0)    begin n_fail++; $display("FAIL midfilt_level got %b want 0", level); end
        n_checks++; if (trig_out !== 1'b0) begin n_fail++; $display("FAIL midfilt_trig got %b want 0", trig_out); end
        repeat (2) tick();
        rst = 1'b0;
        pulses = 0; armed_hi = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (trig_out) pulses++;
            if (armed) armed_hi++;
        end
        n_checks++; if (pulses != 0)    begin n_fail++; $display("FAIL postrst_trig got %0d pulses want 0", pulses); end
        n_checks++; if (armed_hi != 0)  begin n_fail++; $display("FAIL postrst_armed got %0d cycles want 0", armed_hi); end
        n_checks++; if (level !== 1'b1) begin n_fail++; $display("FAIL postrst_level got %b want 1", level); end
        // Reset while ARMED with the filtered level high.
        arm_with(1'b1, 8'd1);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL midarm_armed got %b want 0", armed); end
        n_checks++; if (level !== 1'b0) begin n_fail++; $display("FAIL midarm_level got %b want 0", level); end
        repeat (2) tick();
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (trig_out) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midarm_post_trig got %0d pulses want 0", pulses); end
        settle_low();
    endtask

    task automatic test_timeout();
        int to_pulses;
        int to_at;
`ifdef TRIG_QUAL_TIMEOUT_EN
        to_arm = 1'b1;
        tick();
        to_arm = 1'b0;
        n_checks++; if (to_armed !== 1'b1) begin n_fail++; $display("FAIL to_armed got %b want 1", to_armed); end
        to_pulses = 0; to_at = -1;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (to_timeout) begin to_pulses++; if (to_at < 0) to_at = k; end
        end
        n_checks++; if (to_pulses != 1) begin n_fail++; $display("FAIL to_pulses got %0d want 1", to_pulses); end
        n_checks++; if (to_at != 100)   begin n_fail++; $display("FAIL to_at got %0d want 100", to_at); end
        n_checks++; if (to_armed !== 1'b0 || to_fired !== 1'b0 || to_trig !== 1'b0) begin
            n_fail++; $display("FAIL to_idle got armed=%b fired=%b trig=%b want 0 0 0", to_armed, to_fired, to_trig);
        end
`endif
        // Main instance: timeout far away (or compiled out), stays armed.
        arm_with(1'b1, 8'd1);
        to_pulses = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (timeout) to_pulses++;
        end
        n_checks++; if (to_pulses != 0) begin n_fail++; $display("FAIL main_timeout got %0d pulses want 0", to_pulses); end
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL main_still_armed got %b want 1", armed); end
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_filter();
        test_edge_count();
        test_restart();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_qualifier.md
# trigger_qualifier

Conditions the raw external trigger before it reaches the glitch generator's `trigger` input. Stages:
- synchronises the asynchronous pin;
- rejects pulses shorter than a programmable width;
- selects rising or falling edges;
- counts N qualified edges after an arm command, then emits one single-cycle `trig_out` pulse.

It sits directly upstream of the glitch generator, between the PMOD trigger pin and the generator.

## Interface

- `SYNC_STAGES`, 2 — synchroniser depth; legal range 2..4.
- `FILTER_W`, 16 — filter counter width.
- `FILTER_CYCLES`, 16'd12 — cycles a level must persist to be accepted (1 µs at 12 MHz). 0 means no filtering.
- `COUNT_W`, 8 — edge-count width.
- `TIMEOUT_CYCLES`, 32'd12_000_000 — armed timeout (1 s). Used only with `TRIG_QUAL_TIMEOUT_EN`.

- `clk`  in  1  system clock (12 MHz oscillator domain).
- `rst`  in  1  asynchronous, active-high reset.
- `trig_raw`  in  1  raw trigger pin, asynchronous to `clk`.
- `arm`  in  1  single-cycle arm/re-arm request.
- `edge_sel`  in  1  1 = rising edge, 0 = falling edge. Latched on `arm`.
- `edge_count`  in  COUNT_W  qualified edges required before firing. Latched on `arm`; 0 is treated as 1.
- `trig_out`  out  1  single-cycle pulse to the glitch generator.
- `armed`  out  1  high in ARMED.
- `fired`  out  1  high in FIRED; cleared by `arm`.
- `level`  out  1  filtered trigger level.
- `timeout`  out  1  single-cycle pulse on armed timeout. Tied 0 when the feature is compiled out.

## Operation

Reset values: all outputs are 0; sync flops, `level` and its delayed copy are 0; filter counter is 0; state is IDLE.

- **Synchroniser:** a `SYNC_STAGES`-deep flop chain produces `s`.
- **Filter:**
  - If `s == level`, the counter clears.
  - Otherwise the counter increments. When it would reach `FILTER_CYCLES`, `level <= s` and the counter clears.
  - Any return of `s` to `level` before that point clears the counter; the pulse is rejected.
  - If `FILTER_CYCLES == 0`, `level <= s` every cycle.
  - The counter saturates and never wraps.
- **Edge detect:** `level_d <= level`.
  - Rising edge = `level & ~level_d`.
  - Falling edge = `~level & level_d`.
  - The latched `edge_sel` selects which one is used.
- **FSM:**
  - **IDLE:** `arm` → ARMED. Latch `edge_sel` and load `remaining = max(edge_count, 1)`.
  - **ARMED:**
    - A selected edge with `remaining > 1` decrements `remaining`.
    - A selected edge with `remaining == 1` pulses `trig_out` next cycle and moves to FIRED.
  - **FIRED:** `fired = 1`. `arm` → ARMED with a fresh latch/load.
- **Simultaneous events:**
  - `arm` in ARMED restarts: it reloads `remaining`, relatches `edge_sel`, and discards any edge in the same cycle.
  - An edge in the same cycle as `arm` from IDLE or FIRED is ignored.
- Edges in IDLE or FIRED are ignored. The filter always runs, so `level` tracks the pin in every state.
- **Reset mid-operation:** all state is cleared asynchronously, and a `trig_out` pulse in flight is dropped.

## Timing

- Cycle 0 is the first `clk` edge sampling a new `trig_raw` value.
  - `s` changes after edge `SYNC_STAGES - 1`.
  - `level` changes `FILTER_CYCLES` edges after that (same edge if `FILTER_CYCLES == 0`).
  - `trig_out` is high for exactly one cycle, starting 1 edge after `level` changes.
- Latency with defaults: 2 + 12 + 1 = 15 cycles.
- `armed` and `fired` are registered and change on the same edge as the state.
- `trig_out` rises on the same edge that sets `fired`.
- The minimum accepted pulse width is `FILTER_CYCLES` cycles; a pulse of `FILTER_CYCLES - 1` cycles is always rejected.

## Configuration

- `TRIG_QUAL_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to ARMED and increments each ARMED cycle.
  - When it reaches `TIMEOUT_CYCLES - 1` without firing: state → IDLE, `timeout` pulses for 1 cycle, `trig_out` stays 0.
  - If the firing edge arrives in the same cycle as the timeout, the fire wins.
- Undefined: ARMED persists indefinitely, and `timeout` is constant 0.

## Test plan

- **Basic fire:** defaults, `arm`, `edge_count = 1`, `edge_sel = 1`, `trig_raw` 0→1 held 20 cycles.
  - `trig_out` is a single pulse 15 cycles after the change; `fired = 1` and `armed = 0` from the same edge.
- **Filter:** `trig_raw` high for 11 cycles then low → `level` stays 0 and there is no `trig_out`. A high of 12 cycles → `level` goes 1 and `trig_out` fires.
- **Edge count:** `edge_count = 3`, `edge_sel = 0`, four clean 30-cycle high/low pulses.
  - `trig_out` occurs once, on the 3rd falling edge; the 4th is ignored.
  - `edge_count = 0` fires on the 1st edge.
- **Re-arm/restart:**
  - `arm` in the same cycle as a qualified edge in ARMED → the edge is discarded and the count restarts.
  - `arm` in FIRED → `fired = 0` and `armed = 1` next cycle.
- **Reset:** assert `rst` mid-filter and mid-ARMED → all outputs go 0 immediately. After release, no spurious `trig_out` with `trig_raw` held high.
- **Timeout** (`TRIG_QUAL_TIMEOUT_EN`, `TIMEOUT_CYCLES = 100`): arm with no edges → `timeout` pulses 100 cycles after `armed` rises, then the state is IDLE.
